// File: rtl/reaction_stats_pkg.sv
// ---------------------------------------------------------------------------
// reaction_stats_pkg
//
// Shared definitions for the reaction-game statistics block and the
// reaction_timer producer that feeds it: the result-kind encoding, the
// "no data yet" marker for best_ms, common widths and a saturating
// counter increment.
// ---------------------------------------------------------------------------
package reaction_stats_pkg;

    localparam int RES_MS_W = 16;
    localparam int CNT_W    = 8;

    // best_ms shows this value until the first OK result is published
    localparam logic [RES_MS_W-1:0] NO_DATA_MS = 16'd9999;

    typedef enum logic [1:0] {
        RES_OK      = 2'd0,
        RES_TIMEOUT = 2'd1,
        RES_FALSE   = 2'd2,
        RES_RSVD    = 2'd3
    } res_kind_t;

    // Counters stick at all-ones instead of wrapping back to zero
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/stat_history.sv
// ---------------------------------------------------------------------------
// stat_history
//
// Ring buffer of the most recent DEPTH OK samples together with their
// running sum. A write evicts the entry under the write pointer, so the sum
// always covers exactly the samples currently held in the buffer.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   clear    in   synchronous wipe of buffer, pointer, fill and sum
//   wr_en    in   store sample this cycle
//   sample   in   16-bit value to store (already clamped by the caller)
//   sum      out  running sum of the buffered samples
//   full     out  DEPTH samples have been written since the last wipe
// ---------------------------------------------------------------------------
module stat_history
    import reaction_stats_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int SUM_W = RES_MS_W + PTR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [RES_MS_W-1:0] sample,
    output logic [SUM_W-1:0]    sum,
    output logic                full
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [RES_MS_W-1:0] hist [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W:0]      fill;

    // Each write replaces the oldest entry and adjusts the sum by the
    // difference, so no adder tree over the whole buffer is needed. The sum
    // can never underflow because the evicted entry is part of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
            wr_ptr <= '0;
            fill   <= '0;
            sum    <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
            wr_ptr <= '0;
            fill   <= '0;
            sum    <= '0;
        end else if (wr_en) begin
            sum          <= sum - SUM_W'(hist[wr_ptr]) + SUM_W'(sample);
            hist[wr_ptr] <= sample;
            wr_ptr       <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (fill != FULL_CNT) begin
                fill <= fill + (PTR_W + 1)'(1);
            end
        end
    end

    assign full = (fill == FULL_CNT);

endmodule

// File: rtl/reaction_stats.sv
// ---------------------------------------------------------------------------
// reaction_stats
//
// Collects finished reaction-game attempts and keeps running statistics:
// last and best OK time, the mean of the last HIST_DEPTH OK times, and
// saturating counters for OK, timeout and false-start attempts. An OK
// result takes three cycles (accumulate, divide, publish) during which new
// results are refused and reported on 'dropped'.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   res_valid   in   one-cycle pulse, an attempt result is offered
//   res_kind    in   2-bit result kind (see res_kind_t)
//   res_ms      in   reaction time in ms, used for OK only
//   clear       in   synchronous wipe of all statistics
//   ready       out  a res_valid this cycle will be accepted
//   dropped     out  pulse, a result arrived while busy
//   last_ms     out  most recent OK time
//   best_ms     out  smallest OK time (NO_DATA_MS until one exists)
//   avg_ms      out  mean of the last HIST_DEPTH OK times
//   best_valid  out  best_ms holds a real time
//   avg_valid   out  avg_ms covers a full history window
//   n_ok        out  OK attempts, saturating
//   n_timeout   out  timed-out attempts, saturating
//   n_false     out  false starts, saturating
// ---------------------------------------------------------------------------
module reaction_stats
    import reaction_stats_pkg::*;
#(
    parameter int HIST_DEPTH = 4,
    parameter int MAX_MS     = 999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    input  logic [1:0]  res_kind,
    input  logic [15:0] res_ms,
    input  logic        clear,
    output logic        ready,
    output logic        dropped,
    output logic [15:0] last_ms,
    output logic [15:0] best_ms,
    output logic [15:0] avg_ms,
    output logic        best_valid,
    output logic        avg_valid,
    output logic [7:0]  n_ok,
    output logic [7:0]  n_timeout,
    output logic [7:0]  n_false
);

    localparam int PTR_W = $clog2(HIST_DEPTH);
    localparam int SUM_W = RES_MS_W + PTR_W;

    localparam logic [RES_MS_W-1:0] MAX_CLAMP = RES_MS_W'(MAX_MS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCUM   = 2'd1;
    localparam logic [1:0] S_DIVIDE  = 2'd2;
    localparam logic [1:0] S_PUBLISH = 2'd3;

    logic [1:0]          state;
    logic [RES_MS_W-1:0] sample;
    logic [RES_MS_W-1:0] clamped_ms;
    logic [RES_MS_W-1:0] avg_next;
    logic [SUM_W-1:0]    sum;
    logic                hist_full;
    logic                accept;
    res_kind_t           kind;

    assign kind       = res_kind_t'(res_kind);
    assign ready      = (state == S_IDLE) && !clear;
    assign accept     = res_valid && ready;
    assign clamped_ms = (res_ms > MAX_CLAMP) ? MAX_CLAMP : res_ms;

    stat_history #(
        .DEPTH (HIST_DEPTH),
        .PTR_W (PTR_W),
        .SUM_W (SUM_W)
    ) u_history (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .wr_en  (state == S_ACCUM),
        .sample (sample),
        .sum    (sum),
        .full   (hist_full)
    );

    // Sequencer for OK results. The sample is latched on acceptance, pushed
    // into the history, averaged, then handed to the publish stage. Clear
    // and reset both drop straight back to idle, so a sample in flight never
    // reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sample   <= '0;
            avg_next <= '0;
        end else if (clear) begin
            state    <= S_IDLE;
            sample   <= '0;
            avg_next <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && kind == RES_OK) begin
                        sample <= clamped_ms;
                        state  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    state <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    avg_next <= sum[SUM_W-1:PTR_W];
                    state    <= S_PUBLISH;
                end
                S_PUBLISH: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Visible statistics. Timeout and false-start counts move on the
    // accepting edge since they need no arithmetic; OK results only touch
    // the outputs in the publish cycle. A result offered while busy is
    // thrown away and flagged one cycle later, unless clear is also active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped    <= 1'b0;
            last_ms    <= '0;
            best_ms    <= NO_DATA_MS;
            avg_ms     <= '0;
            best_valid <= 1'b0;
            avg_valid  <= 1'b0;
            n_ok       <= '0;
            n_timeout  <= '0;
            n_false    <= '0;
        end else if (clear) begin
            dropped    <= 1'b0;
            last_ms    <= '0;
            best_ms    <= NO_DATA_MS;
            avg_ms     <= '0;
            best_valid <= 1'b0;
            avg_valid  <= 1'b0;
            n_ok       <= '0;
            n_timeout  <= '0;
            n_false    <= '0;
        end else begin
            dropped <= res_valid && (state != S_IDLE);

            if (accept && kind == RES_TIMEOUT) begin
                n_timeout <= sat_inc(n_timeout);
            end
            if (accept && kind == RES_FALSE) begin
                n_false <= sat_inc(n_false);
            end

            if (state == S_PUBLISH) begin
                last_ms    <= sample;
                best_valid <= 1'b1;
                n_ok       <= sat_inc(n_ok);
                if (!best_valid || sample < best_ms) begin
                    best_ms <= sample;
                end
                if (hist_full) begin
                    avg_ms    <= avg_next;
                    avg_valid <= 1'b1;
                end
            end
        end
    end

endmodule
